// File: rtl/regfile_sb.sv
// ============================================================================
// Module   : regfile_sb
// Brief    : Register file with two combinational read ports, a single-cycle
//            writeback port (with immediate-to-accumulator path), a late
//            writeback port for multi-cycle loads, a per-register pending
//            scoreboard with read-stall outputs and a sticky conflict flag.
// Options  : REGFILE_BYPASS_EN - forward same-cycle write data to the read
//            ports and drop the stall on a same-cycle LoadDone.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb #(
  parameter int W        = 8,
  parameter int D        = 4,
  parameter int ACC_INIT = 30,
  parameter int PRE_ADDR = 2,
  parameter int PRE_VAL  = 5
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [D-1:0]    RaddrA,
  input  logic [D-1:0]    RaddrB,
  output logic [W-1:0]    DataOutA,
  output logic [W-1:0]    DataOutB,
  input  logic            WriteEn,
  input  logic [D-1:0]    Waddr,
  input  logic [W-1:0]    DataIn,
  input  logic            Immediate,
  input  logic [W-1:0]    ImmediateValue,
  input  logic            IssueEn,
  input  logic [D-1:0]    IssueAddr,
  input  logic            LoadDone,
  input  logic [D-1:0]    LoadAddr,
  input  logic [W-1:0]    LoadData,
  output logic            StallA,
  output logic            StallB,
  output logic [2**D-1:0] PendingMask,
  output logic            Conflict,
  output logic [W-1:0]    AccumulatorValue
);

  localparam int             c_NREG     = 2**D;
  localparam logic [W-1:0]   c_ACC_INIT = W'(ACC_INIT);
  localparam logic [W-1:0]   c_PRE_VAL  = W'(PRE_VAL);
  localparam logic [D-1:0]   c_PRE_ADDR = D'(PRE_ADDR);

  logic [W-1:0]      r_mem [c_NREG];
  logic [c_NREG-1:0] r_pending;
  logic              r_conflict;

  logic [D-1:0]      w_wb_addr;
  logic [W-1:0]      w_wb_data;
  logic [c_NREG-1:0] w_pending_nxt;
  logic              w_conf_issue;
  logic              w_conf_load;
  logic              w_conf_wb;
  logic              w_conf_dual;
  logic [W-1:0]      w_data_a;
  logic [W-1:0]      w_data_b;
  logic              w_stall_a;
  logic              w_stall_b;

  // Immediate redirects the writeback port to the accumulator (reg 0).
  assign w_wb_addr = Immediate ? '0 : Waddr;
  assign w_wb_data = Immediate ? ImmediateValue : DataIn;

  // Protocol violations that latch the sticky Conflict flag.
  assign w_conf_issue = IssueEn && r_pending[IssueAddr] &&
                        !(LoadDone && (LoadAddr == IssueAddr));
  assign w_conf_load  = LoadDone && !r_pending[LoadAddr];
  assign w_conf_wb    = WriteEn && r_pending[w_wb_addr];
  assign w_conf_dual  = WriteEn && LoadDone && (w_wb_addr == LoadAddr);

  // Scoreboard update: a completing load clears, a new issue sets (issue wins).
  always_comb begin
    w_pending_nxt = r_pending;
    if (LoadDone) w_pending_nxt[LoadAddr]  = 1'b0;
    if (IssueEn)  w_pending_nxt[IssueAddr] = 1'b1;
  end

  // Storage, scoreboard and conflict state; late load data overrides writeback.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < c_NREG; i++) r_mem[i] <= '0;
      r_mem[0]          <= c_ACC_INIT;
      r_mem[c_PRE_ADDR] <= c_PRE_VAL;
      r_pending         <= '0;
      r_conflict        <= 1'b0;
    end else begin
      if (WriteEn)  r_mem[w_wb_addr] <= w_wb_data;
      if (LoadDone) r_mem[LoadAddr]  <= LoadData;
      r_pending  <= w_pending_nxt;
      if (w_conf_issue || w_conf_load || w_conf_wb || w_conf_dual)
        r_conflict <= 1'b1;
    end
  end

  // Read port A: stored data and stall, optionally forwarded from this cycle's writes.
  always_comb begin
    w_data_a  = r_mem[RaddrA];
    w_stall_a = r_pending[RaddrA];
`ifdef REGFILE_BYPASS_EN
    if (WriteEn && (w_wb_addr == RaddrA)) w_data_a = w_wb_data;
    if (LoadDone && (LoadAddr == RaddrA)) begin
      w_data_a  = LoadData;
      w_stall_a = 1'b0;
    end
`endif
  end

  // Read port B: same behaviour as port A.
  always_comb begin
    w_data_b  = r_mem[RaddrB];
    w_stall_b = r_pending[RaddrB];
`ifdef REGFILE_BYPASS_EN
    if (WriteEn && (w_wb_addr == RaddrB)) w_data_b = w_wb_data;
    if (LoadDone && (LoadAddr == RaddrB)) begin
      w_data_b  = LoadData;
      w_stall_b = 1'b0;
    end
`endif
  end

  assign DataOutA         = w_data_a;
  assign DataOutB         = w_data_b;
  assign StallA           = w_stall_a;
  assign StallB           = w_stall_b;
  assign PendingMask      = r_pending;
  assign Conflict         = r_conflict;
  assign AccumulatorValue = r_mem[0];

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module   : tb_regfile_sb
// Brief    : Directed scoreboard bench for regfile_sb. Stimulus pushes the
//            expected observations for the current cycle; a monitor pops and
//            compares them at the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sb;

  localparam int W = 8;
  localparam int D = 4;

  localparam int K_DA  = 0;
  localparam int K_DB  = 1;
  localparam int K_SA  = 2;
  localparam int K_SB  = 3;
  localparam int K_PM  = 4;
  localparam int K_CF  = 5;
  localparam int K_ACC = 6;

`ifdef REGFILE_BYPASS_EN
  localparam bit c_BYP = 1'b1;
`else
  localparam bit c_BYP = 1'b0;
`endif

  typedef struct {
    int          kind;
    logic [15:0] val;
    string       name;
  } exp_t;

  logic           Clk = 1'b0;
  logic           Reset;
  logic [D-1:0]   RaddrA, RaddrB;
  logic [W-1:0]   DataOutA, DataOutB;
  logic           WriteEn;
  logic [D-1:0]   Waddr;
  logic [W-1:0]   DataIn;
  logic           Immediate;
  logic [W-1:0]   ImmediateValue;
  logic           IssueEn;
  logic [D-1:0]   IssueAddr;
  logic           LoadDone;
  logic [D-1:0]   LoadAddr;
  logic [W-1:0]   LoadData;
  logic           StallA, StallB;
  logic [2**D-1:0] PendingMask;
  logic           Conflict;
  logic [W-1:0]   AccumulatorValue;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  regfile_sb #(.W(W), .D(D), .ACC_INIT(30), .PRE_ADDR(2), .PRE_VAL(5)) dut (
    .Clk(Clk), .Reset(Reset),
    .RaddrA(RaddrA), .RaddrB(RaddrB),
    .DataOutA(DataOutA), .DataOutB(DataOutB),
    .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
    .Immediate(Immediate), .ImmediateValue(ImmediateValue),
    .IssueEn(IssueEn), .IssueAddr(IssueAddr),
    .LoadDone(LoadDone), .LoadAddr(LoadAddr), .LoadData(LoadData),
    .StallA(StallA), .StallB(StallB),
    .PendingMask(PendingMask), .Conflict(Conflict),
    .AccumulatorValue(AccumulatorValue)
  );

  always #5 Clk = ~Clk;

  // Monitor: everything queued during this cycle is checked at the falling edge.
  always @(negedge Clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [15:0] act;
      e = q.pop_front();
      case (e.kind)
        K_DA:    act = 16'(DataOutA);
        K_DB:    act = 16'(DataOutB);
        K_SA:    act = 16'(StallA);
        K_SB:    act = 16'(StallB);
        K_PM:    act = 16'(PendingMask);
        K_CF:    act = 16'(Conflict);
        default: act = 16'(AccumulatorValue);
      endcase
      n_vec++;
      if (act !== e.val) begin
        n_err++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.val);
      end
    end
  end

  task automatic expect_v(input int kind, input logic [15:0] val, input string name);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    WriteEn  = 1'b0; Immediate = 1'b0; IssueEn = 1'b0; LoadDone = 1'b0;
    Reset    = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    RaddrA = '0; RaddrB = '0; Waddr = '0; DataIn = '0; ImmediateValue = '0;
    IssueAddr = '0; LoadAddr = '0; LoadData = '0;
    idle();
    do_reset();

    // Reset contents, every address through both read ports.
    expect_v(K_PM, 16'h0000, "reset_pending");
    expect_v(K_CF, 16'h0,    "reset_conflict");
    expect_v(K_ACC, 16'd30,  "reset_acc");
    for (int i = 0; i < 16; i++) begin
      RaddrA = 4'(i);
      RaddrB = 4'(15 - i);
      expect_v(K_DA, (i == 0) ? 16'd30 : (i == 2) ? 16'd5 : 16'd0, $sformatf("reset_rdA_%0d", i));
      expect_v(K_DB, (15 - i == 0) ? 16'd30 : (15 - i == 2) ? 16'd5 : 16'd0, $sformatf("reset_rdB_%0d", 15 - i));
      tick();
    end

    // Immediate write goes to reg0, Waddr ignored.
    WriteEn = 1'b1; Immediate = 1'b1; ImmediateValue = 8'h7F; Waddr = 4'd5;
    RaddrA = 4'd0; RaddrB = 4'd5;
    expect_v(K_DA, c_BYP ? 16'h7F : 16'd30, "imm_byp_rd0");
    tick();
    idle();
    expect_v(K_DA, 16'h7F, "imm_reg0");
    expect_v(K_DB, 16'h00, "imm_reg5_unchanged");
    expect_v(K_ACC, 16'h7F, "imm_acc");
    tick();
    WriteEn = 1'b1; Immediate = 1'b0; DataIn = 8'h11; Waddr = 4'd5;
    expect_v(K_DB, c_BYP ? 16'h11 : 16'h00, "wb_byp_rd5");
    tick();
    idle();
    expect_v(K_DB, 16'h11, "wb_reg5");
    expect_v(K_DA, 16'h7F, "wb_reg0_kept");
    tick();

    // Issue / complete a load to reg3.
    IssueEn = 1'b1; IssueAddr = 4'd3; RaddrA = 4'd3;
    expect_v(K_SA, 16'h0, "issue_stall_same_cycle");
    tick();
    idle();
    expect_v(K_SA, 16'h1, "issue_stallA");
    expect_v(K_PM, 16'h0008, "issue_pending");
    tick();
    LoadDone = 1'b1; LoadAddr = 4'd3; LoadData = 8'hA5;
    expect_v(K_DA, c_BYP ? 16'hA5 : 16'h00, "load_byp_data");
    expect_v(K_SA, c_BYP ? 16'h0 : 16'h1, "load_byp_stall");
    tick();
    idle();
    expect_v(K_DA, 16'hA5, "load_reg3");
    expect_v(K_SA, 16'h0, "load_stall_clear");
    expect_v(K_PM, 16'h0000, "load_pending_clear");
    expect_v(K_CF, 16'h0, "load_no_conflict");
    tick();

    // Both write ports to reg4: LoadData wins, Conflict sticks.
    WriteEn = 1'b1; Waddr = 4'd4; DataIn = 8'h01;
    LoadDone = 1'b1; LoadAddr = 4'd4; LoadData = 8'h02; RaddrA = 4'd4;
    expect_v(K_DA, c_BYP ? 16'h02 : 16'h00, "dual_byp_data");
    tick();
    idle();
    expect_v(K_DA, 16'h02, "dual_reg4");
    expect_v(K_CF, 16'h1, "dual_conflict");
    tick();
    tick();
    expect_v(K_CF, 16'h1, "dual_conflict_held");
    do_reset();
    expect_v(K_CF, 16'h0, "dual_conflict_reset");

    // LoadDone to non-pending reg6.
    LoadDone = 1'b1; LoadAddr = 4'd6; LoadData = 8'h66;
    tick();
    idle();
    RaddrA = 4'd6;
    expect_v(K_DA, 16'h66, "np_load_reg6");
    expect_v(K_CF, 16'h1, "np_load_conflict");
    do_reset();

    // Double issue to reg7.
    IssueEn = 1'b1; IssueAddr = 4'd7;
    tick();
    RaddrB = 4'd7;
    expect_v(K_SB, 16'h1, "dbl_issue_stallB");
    expect_v(K_CF, 16'h0, "dbl_issue_first_ok");
    tick();
    idle();
    expect_v(K_CF, 16'h1, "dbl_issue_conflict");
    expect_v(K_PM, 16'h0080, "dbl_issue_pending");
    do_reset();

    // Issue + LoadDone same address: data written, pending kept, no conflict.
    IssueEn = 1'b1; IssueAddr = 4'd9;
    tick();
    IssueEn = 1'b1; IssueAddr = 4'd9; LoadDone = 1'b1; LoadAddr = 4'd9; LoadData = 8'h99;
    tick();
    idle();
    RaddrA = 4'd9;
    expect_v(K_DA, 16'h99, "reissue_reg9");
    expect_v(K_PM, 16'h0200, "reissue_pending");
    expect_v(K_CF, 16'h0, "reissue_no_conflict");
    tick();

    // Writeback to pending reg9: write occurs, pending kept, conflict set.
    WriteEn = 1'b1; Waddr = 4'd9; DataIn = 8'h55;
    tick();
    idle();
    expect_v(K_DA, 16'h55, "wbpend_reg9");
    expect_v(K_PM, 16'h0200, "wbpend_pending");
    expect_v(K_CF, 16'h1, "wbpend_conflict");
    IssueEn = 1'b1; IssueAddr = 4'd1;
    tick();

    // Reset overrides active strobes with pending bits set.
    Reset = 1'b1; LoadDone = 1'b1; LoadAddr = 4'd2; LoadData = 8'hFF;
    WriteEn = 1'b1; Waddr = 4'd0; DataIn = 8'hEE; IssueEn = 1'b1; IssueAddr = 4'd3;
    tick();
    idle();
    RaddrA = 4'd2; RaddrB = 4'd9;
    expect_v(K_DA, 16'd5, "rst_reg2");
    expect_v(K_DB, 16'd0, "rst_reg9");
    expect_v(K_ACC, 16'd30, "rst_acc");
    expect_v(K_PM, 16'h0000, "rst_pending");
    expect_v(K_CF, 16'h0, "rst_conflict");
    @(negedge Clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
